conv_block_scheduler: RTL and testbench

//  Sequences the address FSM (Fsmv) of the 2D convolution datapath across an image split

---
 rtl/conv_block_scheduler.sv | 129 ++++++++++++
 tb/tb_conv_block_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_block_scheduler.sv
// Block sequencer in front of Fsmv: per column block it opens the line-memory write
// window, pulses start-of-process and waits for end-of-process, guarded by a RUN watchdog.
module conv_block_scheduler #(
    parameter int NB_IMAGE   = 10,
    parameter int NB_BLOCK   = 8,
    parameter int NB_TIMEOUT = 16
) (
    input  logic                i_CLK,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_IMAGE-1:0] i_imgLength,
    input  logic [NB_BLOCK-1:0] i_nBlocks,
    input  logic                i_loadVld,
    input  logic                i_EoP,
    output logic                o_SoP,
    output logic [NB_IMAGE-1:0] o_imgLength,
    output logic                o_loadEn,
    output logic [NB_BLOCK-1:0] o_blockIdx,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_NEXT, S_DONE
    } state_t;

    // The watchdog expires on the RUN cycle whose increment would reach 2**NB_TIMEOUT-1,
    // so a silent Fsmv keeps us in RUN for exactly 2**NB_TIMEOUT-1 cycles.
    localparam logic [NB_TIMEOUT-1:0] WD_LAST = {{(NB_TIMEOUT-1){1'b1}}, 1'b0};

    state_t              state, state_nxt;
    logic [NB_BLOCK-1:0] nblk;
    logic [NB_IMAGE-1:0] ld_cnt;
    logic [NB_TIMEOUT-1:0] wd;
    logic                sop_d, busy_d, done_d;
    logic                accept, ld_last, wd_expire, blk_last;

    assign accept    = (state == S_IDLE) && i_start;
    assign ld_last   = (state == S_LOAD) && i_loadVld && (ld_cnt == o_imgLength - 1'b1);
    assign wd_expire = (state == S_RUN) && !i_EoP && (wd == WD_LAST);
    assign blk_last  = (o_blockIdx == nblk - 1'b1);
    assign o_loadEn  = (state == S_LOAD) && i_loadVld;

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            state  <= S_IDLE;
            o_SoP  <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_SoP  <= sop_d;
            o_busy <= busy_d;
            o_done <= done_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_imgLength == '0 || i_nBlocks == '0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_LOAD;
                end
            end
            S_LOAD:  if (ld_last) state_nxt = S_START;
            S_START: state_nxt = S_RUN;
            S_RUN: begin
                if (i_EoP)
                    state_nxt = S_NEXT;
                else if (wd_expire)
                    state_nxt = S_IDLE;
            end
            S_NEXT:  state_nxt = blk_last ? S_DONE : S_LOAD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        sop_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_nxt)
            S_LOAD, S_RUN, S_NEXT: busy_d = 1'b1;
            S_START: begin
                busy_d = 1'b1;
                sop_d  = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_reset) begin
        if (!i_reset) begin
            o_imgLength <= '0;
            nblk        <= '0;
            o_blockIdx  <= '0;
            o_error     <= 1'b0;
            ld_cnt      <= '0;
            wd          <= '0;
        end else begin
            if (accept) begin
                o_imgLength <= i_imgLength;
                nblk        <= i_nBlocks;
                o_blockIdx  <= '0;
                o_error     <= 1'b0;
                ld_cnt      <= '0;
            end
            if (o_loadEn)
                ld_cnt <= ld_last ? '0 : ld_cnt + 1'b1;
            if (state == S_RUN && !i_EoP && !wd_expire)
                wd <= wd + 1'b1;
            else
                wd <= '0;
            if (wd_expire)
                o_error <= 1'b1;
            if (state == S_NEXT && !blk_last)
                o_blockIdx <= o_blockIdx + 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_block_scheduler.sv
// Scoreboarded bench for conv_block_scheduler: SoP/done/error events are queued when
// stimulus is driven and matched by a negedge monitor; latencies are checked inline.
module tb_conv_block_scheduler;

    localparam int NB_IMAGE   = 10;
    localparam int NB_BLOCK   = 8;
    localparam int NB_TIMEOUT = 4;
    localparam int RUN_MAX    = 15;

    localparam int EV_SOP  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int kind;
        int idx;
    } ev_t;

    logic                i_CLK = 1'b0;
    logic                i_reset = 1'b0;
    logic                i_start = 1'b0;
    logic [NB_IMAGE-1:0] i_imgLength = '0;
    logic [NB_BLOCK-1:0] i_nBlocks = '0;
    logic                i_loadVld = 1'b0;
    logic                i_EoP = 1'b0;
    logic                o_SoP, o_loadEn, o_busy, o_done, o_error;
    logic [NB_IMAGE-1:0] o_imgLength;
    logic [NB_BLOCK-1:0] o_blockIdx;

    int  nchk = 0;
    int  nfail = 0;
    ev_t exp_q[$];
    bit  err_q = 1'b0;

    conv_block_scheduler #(
        .NB_IMAGE(NB_IMAGE), .NB_BLOCK(NB_BLOCK), .NB_TIMEOUT(NB_TIMEOUT)
    ) dut (
        .i_CLK(i_CLK), .i_reset(i_reset), .i_start(i_start),
        .i_imgLength(i_imgLength), .i_nBlocks(i_nBlocks),
        .i_loadVld(i_loadVld), .i_EoP(i_EoP),
        .o_SoP(o_SoP), .o_imgLength(o_imgLength), .o_loadEn(o_loadEn),
        .o_blockIdx(o_blockIdx), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_pop(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("sb_unexpected", kind, -1);
        end else begin
            e = exp_q.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_idx", int'(o_blockIdx), e.idx);
        end
    endtask

    always @(negedge i_CLK) begin
        if (i_reset) begin
            if (o_SoP) sb_pop(EV_SOP);
            if (o_done) sb_pop(EV_DONE);
            if (o_error && !err_q) sb_pop(EV_ERR);
            err_q = o_error;
        end else begin
            err_q = 1'b0;
        end
    end

    task automatic cyc();
        @(negedge i_CLK);
    endtask

    task automatic push(input int kind, input int idx);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic start(input int l, input int n);
        i_imgLength = l[NB_IMAGE-1:0];
        i_nBlocks   = n[NB_BLOCK-1:0];
        i_start     = 1'b1;
        if (l == 0 || n == 0) push(EV_DONE, 0);
        cyc();
        i_start = 1'b0;
        if (l == 0 || n == 0) begin
            chk("zero_done", o_done, 1);
            chk("zero_busy", o_busy, 0);
        end else begin
            chk("acc_busy", o_busy, 1);
            chk("acc_len", int'(o_imgLength), l);
            chk("acc_idx", int'(o_blockIdx), 0);
            chk("acc_err", o_error, 0);
        end
    endtask

    // Drives L strobes (with idle gaps); returns mid-way through the first RUN cycle.
    task automatic load_block(input int l, input int idx);
        for (int k = 0; k < l; k++) begin
            if (k % 4 == 3) begin
                i_loadVld = 1'b0;
                cyc();
                chk("gap_sop", o_SoP, 0);
            end
            i_loadVld = 1'b1;
            #1 chk("load_en", o_loadEn, 1);
            if (k == l - 1) push(EV_SOP, idx);
            cyc();
            if (k < l - 1) chk("sop_early", o_SoP, 0);
            else           chk("sop_lat", o_SoP, 1);
        end
        i_loadVld = 1'b0;
        cyc();
        chk("sop_pulse", o_SoP, 0);
        chk("run_busy", o_busy, 1);
    endtask

    // EoP lands in RUN cycle 1+dly.
    task automatic finish_block(input int dly, input bit last);
        repeat (dly) cyc();
        i_EoP = 1'b1;
        cyc();
        i_EoP = 1'b0;
        chk("next_busy", o_busy, 1);
        chk("next_err", o_error, 0);
        if (last) push(EV_DONE, int'(o_blockIdx));
        cyc();
        chk("done_lat", o_done, int'(last));
        if (last) begin
            cyc();
            chk("done_pulse", o_done, 0);
            chk("done_busy", o_busy, 0);
        end else begin
            chk("reload_busy", o_busy, 1);
        end
    endtask

    initial begin
        int n;

        #3;
        chk("rst_busy", o_busy, 0);
        chk("rst_sop", o_SoP, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_error, 0);
        chk("rst_idx", int'(o_blockIdx), 0);
        chk("rst_len", int'(o_imgLength), 0);
        cyc();
        i_reset = 1'b1;
        cyc();

        // Two blocks of 15 pixels
        start(15, 2);
        load_block(15, 0);
        finish_block(5, 1'b0);
        chk("blk1_idx", int'(o_blockIdx), 1);
        load_block(15, 1);
        finish_block(2, 1'b1);

        // Degenerate configurations: done right after accept, no load window
        i_loadVld = 1'b1;
        start(0, 2);
        #1 chk("zero_loaden", o_loadEn, 0);
        cyc();
        chk("zero_done_pulse", o_done, 0);
        start(7, 0);
        #1 chk("zero_loaden2", o_loadEn, 0);
        cyc();
        i_loadVld = 1'b0;

        // Watchdog expiry, then a new start clears the error
        start(3, 1);
        load_block(3, 0);
        push(EV_ERR, 0);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (o_error) break;
            n++;
        end
        chk("wd_cycles", n, RUN_MAX);
        chk("wd_err", o_error, 1);
        chk("wd_busy", o_busy, 0);
        chk("wd_nodone", o_done, 0);
        start(3, 1);
        load_block(3, 0);
        finish_block(1, 1'b1);

        // EoP on the terminal watchdog cycle wins
        start(3, 1);
        load_block(3, 0);
        finish_block(RUN_MAX - 1, 1'b1);
        chk("tc_err", o_error, 0);

        // Ignored start/strobes and config changes during RUN
        start(4, 2);
        load_block(4, 0);
        i_start = 1'b1;
        i_loadVld = 1'b1;
        i_imgLength = 10'd9;
        i_nBlocks = 8'd1;
        #1 chk("run_loaden", o_loadEn, 0);
        cyc();
        i_start = 1'b0;
        i_loadVld = 1'b0;
        chk("run_len", int'(o_imgLength), 4);
        chk("run_idx", int'(o_blockIdx), 0);
        chk("run_busy2", o_busy, 1);
        finish_block(2, 1'b0);
        load_block(4, 1);
        finish_block(0, 1'b1);
        i_loadVld = 1'b1;
        #1 chk("idle_loaden", o_loadEn, 0);
        cyc();
        i_loadVld = 1'b0;

        // Asynchronous reset in the middle of LOAD
        start(15, 1);
        for (int k = 0; k < 7; k++) begin
            i_loadVld = 1'b1;
            cyc();
        end
        #2 i_reset = 1'b0;
        #1;
        chk("arst_busy", o_busy, 0);
        chk("arst_loaden", o_loadEn, 0);
        chk("arst_sop", o_SoP, 0);
        chk("arst_len", int'(o_imgLength), 0);
        chk("arst_idx", int'(o_blockIdx), 0);
        cyc();
        i_loadVld = 1'b0;
        i_reset = 1'b1;
        cyc();
        start(15, 1);
        load_block(15, 0);
        finish_block(3, 1'b1);

        repeat (3) cyc();
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout got=%0t exp=finish", $time);
        $fatal(1, "bench timeout");
    end

endmodule
